// File: rtl/serial_rx_control.sv
// serial_rx_control: receive-side control FSM for serial port modes 1, 2 and 3.
// Synchronises RXD and takes 16 samples per bit from the baud tick. Each bit is
// decided by a 2-of-3 vote of the samples around mid-bit. The FSM steps through
// the start, data, ninth and stop bits. It drives the shifter strobe, the SBUF
// load, RB8 and RI.
// Optional build macro SERIAL_RX_FRAME_ERR_EN adds serial_frame_err_o. With it,
// frames whose stop bit is 0 are discarded in every mode.
`timescale 1ns/1ps

module serial_rx_control #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic serial_clock_i,
  input  logic serial_reset_i_b,
  input  logic serial_br_i,
  input  logic serial_rxd_i,
  input  logic serial_scon7_sm0_i,
  input  logic serial_scon6_sm1_i,
  input  logic serial_scon5_sm2_i,
  input  logic serial_scon4_ren_i,
  input  logic serial_scon0_ri_i,
  output logic serial_shift_o,
  output logic serial_rx_bit_o,
  output logic serial_load_sbuf_o,
  output logic serial_scon0_ri_o,
  output logic serial_rb8_we_o,
  output logic serial_scon2_rb8_o,
  output logic serial_busy_o
`ifdef SERIAL_RX_FRAME_ERR_EN
  ,
  output logic serial_frame_err_o
`endif
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  // Mid-bit sample points: the vote uses counter values MID-1, MID and MID+1.
  localparam int MID  = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_NINTH,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [1:0]       r_mode;
  logic             r_rxd_meta;
  logic             r_rxd_sync;
  logic             r_rxd_dly;
  logic             r_br_dly;
  logic             r_s_early;
  logic             r_s_mid;
  logic             r_rb8;
  logic             r_shift;
  logic             r_rx_bit;
  logic             r_load;
  logic             r_ri;
  logic             r_rb8_we;
  logic             r_rb8_out;
  logic             r_busy;
  logic             r_ferr;

  logic             w_tick;
  logic             w_fall;
  logic [1:0]       w_mode;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wrap;
  logic             w_decide;
  logic             w_vote;
  logic             w_abort;
  logic             w_stop_rb8;
  logic             w_load_ok;

  // Synchroniser for RXD. It also holds the delayed copies used to detect the
  // RXD start edge and the baud-tick edge.
  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_dly  <= 1'b1;
      r_br_dly   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is three stages deep.
      r_rxd_meta <= serial_rxd_i;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_dly  <= r_rxd_sync;
      r_br_dly   <= serial_br_i;
    end
  end

  assign w_tick     = serial_br_i & ~r_br_dly;
  assign w_fall     = r_rxd_dly & ~r_rxd_sync;
  assign w_mode     = {serial_scon7_sm0_i, serial_scon6_sm1_i};
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_wrap     = w_tick && (r_cnt == CNT_W'(OVERSAMPLE - 1));
  assign w_decide   = w_tick && (w_cnt_inc == CNT_W'(MID + 1));
  assign w_vote     = (r_s_early & r_s_mid) | (r_s_early & r_rxd_sync) | (r_s_mid & r_rxd_sync);
  assign w_abort    = (r_state != S_IDLE) && (!serial_scon4_ren_i || (w_mode != r_mode));
  // In mode 1 the stop bit becomes RB8. In modes 2/3 RB8 is the ninth bit captured earlier.
  assign w_stop_rb8 = (r_mode == 2'b01) ? w_vote : r_rb8;
`ifdef SERIAL_RX_FRAME_ERR_EN
  assign w_load_ok  = !serial_scon0_ri_i && (!serial_scon5_sm2_i || w_stop_rb8) && w_vote;
`else
  assign w_load_ok  = !serial_scon0_ri_i && (!serial_scon5_sm2_i || w_stop_rb8);
`endif

  // Frame sequencer: counts oversample ticks, votes each bit and issues strobes.
  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_mode    <= 2'b00;
      r_s_early <= 1'b0;
      r_s_mid   <= 1'b0;
      r_rb8     <= 1'b0;
      r_shift   <= 1'b0;
      r_rx_bit  <= 1'b0;
      r_load    <= 1'b0;
      r_ri      <= 1'b0;
      r_rb8_we  <= 1'b0;
      r_rb8_out <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_shift  <= 1'b0;
      r_load   <= 1'b0;
      r_ri     <= 1'b0;
      r_rb8_we <= 1'b0;
      r_ferr   <= 1'b0;

      if (w_abort) begin
        // Receive disabled or mode changed mid-frame: drop the frame silently.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_mode == 2'b00) begin
          r_rx_bit  <= 1'b0;
          r_rb8_out <= 1'b0;
        end else if (serial_scon4_ren_i && w_fall) begin
          r_state   <= S_START;
          r_busy    <= 1'b1;
          r_mode    <= w_mode;
          r_bit_cnt <= '0;
        end
      end else begin
        if (w_tick) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == CNT_W'(MID - 1)) r_s_early <= r_rxd_sync;
          if (w_cnt_inc == CNT_W'(MID))     r_s_mid   <= r_rxd_sync;
        end

        case (r_state)
          S_START: begin
            if (w_decide && w_vote) begin
              // Line was high again by mid-bit: glitch, not a start bit.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else if (w_wrap) begin
              r_state <= S_DATA;
            end
          end

          S_DATA: begin
            if (w_decide) begin
              r_shift   <= 1'b1;
              r_rx_bit  <= w_vote;
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end else if (w_wrap && (r_bit_cnt == BC_W'(DATA_BITS))) begin
              r_bit_cnt <= '0;
              r_state   <= (r_mode == 2'b01) ? S_STOP : S_NINTH;
            end
          end

          S_NINTH: begin
            if (w_decide) begin
              r_rb8 <= w_vote;
            end else if (w_wrap) begin
              r_state <= S_STOP;
            end
          end

          S_STOP: begin
            if (w_decide) begin
              r_rb8 <= w_stop_rb8;
              if (w_load_ok) begin
                r_load    <= 1'b1;
                r_ri      <= 1'b1;
                r_rb8_we  <= 1'b1;
                r_rb8_out <= w_stop_rb8;
              end
              r_ferr  <= ~w_vote;
              // Finish mid stop bit so that a following start edge is not missed.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign serial_shift_o     = r_shift;
  assign serial_rx_bit_o    = r_rx_bit;
  assign serial_load_sbuf_o = r_load;
  assign serial_scon0_ri_o  = r_ri;
  assign serial_rb8_we_o    = r_rb8_we;
  assign serial_scon2_rb8_o = r_rb8_out;
  assign serial_busy_o      = r_busy;
`ifdef SERIAL_RX_FRAME_ERR_EN
  assign serial_frame_err_o = r_ferr;
`else
  // Stop-bit errors are not reported in this build.
  logic w_ferr_unused;
  assign w_ferr_unused = r_ferr;
`endif

endmodule
